unit_sweeper: RTL and testbench
===============================

# unit_sweeper

Sequential test driver for a combinational N-input, 1-output logic unit. It steps the unit's input bus through all 2^N patterns, samples the unit's output after a programmable settle time, and builds the unit's truth table. It then compares the table against an expected value and reports pass/fail plus the first failing pattern. It drives the unit's `i` port and consumes its `y` port.

## Interface
Parameters:
- `N`, 4, width of the unit's input bus; truth table is 2^N bits.
- `SETTLE`, 1, cycles a pattern is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `exp_table`  in  2^N  expected truth table, bit k = expected `y` for input k; sampled in the DONE-entry cycle.
- `i_out`  out  N  pattern to the unit's `i`.
- `y_in`  in  1  the unit's `y`.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left.
- `done`  out  1  one-cycle pulse, sweep complete.
- `table_out`  out  2^N  captured truth table.
- `pass`  out  1  `table_out == exp_table`; valid from `done`, held until next accepted `start`.
- `first_fail`  out  N  lowest index k where `table_out[k] != exp_table[k]`; 0 when `pass`.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: `busy`=0. `i_out`, `table_out`, `pass` and `first_fail` hold their last values.
- IDLE and `start`=1: go to APPLY. Set idx=0, settle count=0, `table_out`=0, `pass`=0, `first_fail`=0.
- APPLY: `i_out`=idx (registered). Count SETTLE cycles, then go to SAMPLE.
- SAMPLE: capture `table_out[idx] <= y_in` at the end of the cycle.
  - If idx = 2^N−1, go to DONE.
  - Otherwise idx++, clear the count and go to APPLY.
- DONE: one cycle. `done`=1. Register `pass` and `first_fail`, computed by a priority scan over `table_out ^ exp_table`. Then go to IDLE.
- `start` while not in IDLE: ignored, no queuing.
- idx is N+1 bits internally, so the terminal compare needs no wrap. `i_out` is idx[N-1:0].

## Timing
- Reset values: state=IDLE, `i_out`=0, `busy`=0, `done`=0, `table_out`=0, `pass`=0, `first_fail`=0.
- Reset mid-sweep aborts immediately. No `done` pulse; the table is cleared.
- `start` high at edge t (in IDLE): APPLY begins at t+1 and `busy`=1 from t+1.
- Each pattern occupies SETTLE+1 cycles: SETTLE in APPLY, 1 in SAMPLE. `i_out` is stable across all of them.
- `done` is high in cycle t+1+2^N·(SETTLE+1). For N=4, SETTLE=1, that is t+33.
- `busy` falls in the cycle after `done`. `start` is accepted again in that same cycle, giving back-to-back sweeps.
- `y_in` must settle within SETTLE cycles of an `i_out` change. The block itself does not check this.
- `table_out` is updated bit by bit during the sweep. It is final only when `done`=1.

## Structure
- Shared include `sweep_defs.vh`: state encodings (IDLE=2'd0, APPLY=2'd1, SAMPLE=2'd2, DONE=2'd3) and the SETTLE range limit.
- One sub-module, `fail_finder`: combinational priority encoder.
  - Inputs: 2^N-bit mismatch vector.
  - Outputs: lowest set index (N bits) and an any-set flag.
  - The top level registers both outputs in DONE.
- Top level: FSM, idx counter, settle counter, table register.

## Test plan
- Unit = 4-input XOR, `exp_table`=16'h6996, `start` pulse.
  - Required: `done` at t+33, `table_out`=16'h6996, `pass`=1, `first_fail`=0.
  - Required: `i_out` walks 0..15, each value held 2 cycles.
- Unit = 4-input AND, `exp_table`=16'h8000.
  - Required: `pass`=1.
  - Then set `exp_table`=16'h8004 and rerun: `pass`=0, `first_fail`=2.
- Mismatch only at bit 15 (expected 16'h0000, unit AND).
  - Required: `first_fail`=15, `pass`=0.
- `start` held high continuously.
  - Required: sweeps run back-to-back with one idle cycle between them.
  - Required: `done` pulses every 34 cycles.
  - Required: `start` pulses mid-sweep have no effect.
- `rst` asserted at pattern 7, between clock edges.
  - Required: all outputs 0 immediately (asynchronous), no `done` pulse.
  - Required: a fresh `start` completes a full, correct sweep.
- SETTLE=3, unit output delayed 2 cycles.
  - Required: correct table, `done` at t+65.

Source files
------------

// File: rtl/unit_sweeper_pkg.sv
// Shared definitions for the unit_sweeper block.
// Contents:
//   state_e    - sweep FSM state encoding (Idle=0, Apply=1, Sample=2, Done=3)
//   SettleMax  - largest supported settle time, in cycles
//   SettleW    - width of the settle counter, sized to hold SettleMax
package unit_sweeper_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StApply  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned SettleMax = 15;
  localparam int unsigned SettleW   = 4;

endpackage

// File: rtl/unit_sweeper_fail_finder.sv
// fail_finder: combinational priority encoder over a mismatch vector.
// Ports:
//   vec  in   2^N  mismatch bits, bit k set when pattern k disagrees
//   idx  out  N    lowest set bit index, 0 when no bit is set
//   any  out  1    at least one bit of vec is set
module fail_finder #(
  parameter int unsigned N = 4
) (
  input  logic [2**N-1:0] vec,
  output logic [N-1:0]    idx,
  output logic            any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan high to low so the lowest set bit is the last one written.
    for (int k = 2**N - 1; k >= 0; k--) begin
      if (vec[k]) idx = N'(k);
    end
  end

endmodule

// File: rtl/unit_sweeper.sv
// unit_sweeper: steps a combinational N-input unit through all 2^N input
// patterns, samples its output after SETTLE cycles per pattern, builds the
// truth table and compares it against an expected table.
// Ports:
//   clk         in   1    clock, all state on rising edge
//   rst         in   1    asynchronous active-high reset
//   start       in   1    begin a sweep, honoured only when idle
//   exp_table   in   2^N  expected truth table, bit k = expected y for input k
//   i_out       out  N    pattern driven to the unit's input bus
//   y_in        in   1    unit output
//   busy        out  1    sweep in progress (through the done cycle)
//   done        out  1    one-cycle pulse at sweep completion
//   table_out   out  2^N  captured truth table
//   pass        out  1    table_out matched exp_table
//   first_fail  out  N    lowest mismatching pattern, 0 on pass
module unit_sweeper
  import unit_sweeper_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2**N-1:0] exp_table,
  output logic [N-1:0]    i_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] table_out,
  output logic            pass,
  output logic [N-1:0]    first_fail
);

  localparam int unsigned Patterns = 2**N;
  localparam logic [N:0]  LastIdx  = (N+1)'(Patterns - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);

  state_e               state;
  logic [N:0]           idx;
  logic [SettleW-1:0]   cnt;
  logic [Patterns-1:0]  table_nxt;
  logic [Patterns-1:0]  mismatch;
  logic [N-1:0]         ff_idx;
  logic                 ff_any;

  // Table including the bit being sampled this cycle, so the verdict can be
  // registered together with the done pulse and is valid while done is high.
  always_comb begin
    table_nxt                = table_out;
    table_nxt[idx[N-1:0]]    = y_in;
    mismatch                 = table_nxt ^ exp_table;
  end

  fail_finder #(
    .N(N)
  ) u_fail_finder (
    .vec(mismatch),
    .idx(ff_idx),
    .any(ff_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      idx        <= '0;
      cnt        <= '0;
      i_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      pass       <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StApply;
            busy       <= 1'b1;
            idx        <= '0;
            cnt        <= '0;
            i_out      <= '0;
            table_out  <= '0;
            pass       <= 1'b0;
            first_fail <= '0;
          end
        end
        StApply: begin
          if (cnt == SettleLast) begin
            state <= StSample;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StSample: begin
          table_out <= table_nxt;
          if (idx == LastIdx) begin
            state      <= StDone;
            done       <= 1'b1;
            pass       <= ~ff_any;
            first_fail <= ff_idx;
          end else begin
            idx   <= idx + 1'b1;
            i_out <= idx[N-1:0] + 1'b1;
            cnt   <= '0;
            state <= StApply;
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_sweeper.sv
// Self-checking bench for unit_sweeper: directed sweeps with a scoreboard of
// expected done cycle, table and verdict, popped by per-DUT done monitors.
module tb_unit_sweeper;

  localparam int unsigned N = 4;

  typedef struct {
    int          done_cyc;
    logic [15:0] tbl;
    logic        pass;
    logic [3:0]  ff;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // DUT1: SETTLE=1, unit reacts immediately
  logic        start1 = 1'b0;
  logic [15:0] exp1 = '0;
  logic [3:0]  i1;
  logic        y1;
  logic        busy1, done1, pass1;
  logic [15:0] tbl1;
  logic [3:0]  ff1;
  logic        mode1 = 1'b0;  // 0: XOR, 1: AND

  // DUT2: SETTLE=3, unit output delayed two cycles
  logic        start2 = 1'b0;
  logic [15:0] exp2 = '0;
  logic [3:0]  i2;
  logic        y2;
  logic        busy2, done2, pass2;
  logic [15:0] tbl2;
  logic [3:0]  ff2;
  logic [3:0]  d1, d2;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic unit_f(logic m, logic [3:0] v);
    return m ? (&v) : (^v);
  endfunction

  assign y1 = unit_f(mode1, i1);

  always @(posedge clk) begin
    d1 <= i2;
    d2 <= d1;
  end
  assign y2 = unit_f(1'b0, d2);

  unit_sweeper #(.N(N), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .exp_table(exp1), .i_out(i1), .y_in(y1),
    .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1), .first_fail(ff1)
  );

  unit_sweeper #(.N(N), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .exp_table(exp2), .i_out(i2), .y_in(y2),
    .busy(busy2), .done(done2), .table_out(tbl2), .pass(pass2), .first_fail(ff2)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitors: pop the scoreboard on every done pulse.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", done1, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("done1_cycle", cyc, e.done_cyc);
        chk("table1", tbl1, e.tbl);
        chk("pass1", pass1, e.pass);
        chk("first_fail1", ff1, e.ff);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && done2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", done2, 1'b0);
      end else begin
        e = q2.pop_front();
        chk("done2_cycle", cyc, e.done_cyc);
        chk("table2", tbl2, e.tbl);
        chk("pass2", pass2, e.pass);
        chk("first_fail2", ff2, e.ff);
      end
    end
  end

  task automatic push1(int dcyc, logic [15:0] t, logic p, logic [3:0] f);
    exp_t e;
    e.done_cyc = dcyc; e.tbl = t; e.pass = p; e.ff = f;
    q1.push_back(e);
  endtask

  task automatic wait_idle1(int limit);
    int n = 0;
    @(negedge clk);
    while (busy1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("sweep1_end", busy1, 1'b0);
  endtask

  // One pulse-started sweep on DUT1; called at a negedge.
  task automatic sweep1(logic m, logic [15:0] e, logic [15:0] t, logic p, logic [3:0] f);
    mode1 = m;
    exp1  = e;
    push1(cyc + 33, t, p, f);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_idle1(100);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int  n;
    bit  seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_i_out", i1, 4'h0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_table", tbl1, 16'h0);
    chk("rst_pass", pass1, 1'b0);
    chk("rst_first_fail", ff1, 4'h0);

    // XOR sweep with i_out walk and an ignored mid-sweep start pulse
    mode1 = 1'b0;
    exp1  = 16'h6996;
    push1(cyc + 33, 16'h6996, 1'b1, 4'd0);
    start1 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("i_out_walk", i1, 32'(k / 2));
      chk("busy_during", busy1, 1'b1);
      start1 = (k == 10);
    end
    start1 = 1'b0;
    wait_idle1(100);
    repeat (3) @(negedge clk);
    chk("pass_held", pass1, 1'b1);
    chk("i_out_held", i1, 4'hf);

    // AND unit
    sweep1(1'b1, 16'h8000, 16'h8000, 1'b1, 4'd0);
    sweep1(1'b1, 16'h8004, 16'h8000, 1'b0, 4'd2);
    sweep1(1'b1, 16'h0000, 16'h8000, 1'b0, 4'd15);

    // start held: back-to-back sweeps, done every 34 cycles
    mode1 = 1'b0;
    exp1  = 16'h6996;
    push1(cyc + 33,  16'h6996, 1'b1, 4'd0);
    push1(cyc + 67,  16'h6996, 1'b1, 4'd0);
    push1(cyc + 101, 16'h6996, 1'b1, 4'd0);
    start1 = 1'b1;
    repeat (80) @(negedge clk);
    start1 = 1'b0;
    wait_idle1(100);
    repeat (3) @(negedge clk);
    chk("no_extra_sweep", busy1, 1'b0);

    // Asynchronous reset at pattern 7
    push1(cyc + 33, 16'h6996, 1'b1, 4'd0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (i1 !== 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pattern7", i1, 4'd7);
    #2 rst = 1'b1;
    #1;
    chk("arst_i_out", i1, 4'h0);
    chk("arst_busy", busy1, 1'b0);
    chk("arst_done", done1, 1'b0);
    chk("arst_table", tbl1, 16'h0);
    chk("arst_pass", pass1, 1'b0);
    chk("arst_first_fail", ff1, 4'h0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    chk("no_done_after_rst", seen, 1'b0);
    sweep1(1'b0, 16'h6996, 16'h6996, 1'b1, 4'd0);

    // SETTLE=3 with a two-cycle-late unit
    begin
      exp_t e;
      exp2 = 16'h6996;
      e.done_cyc = cyc + 65; e.tbl = 16'h6996; e.pass = 1'b1; e.ff = 4'd0;
      q2.push_back(e);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (busy2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("sweep2_end", busy2, 1'b0);
    end

    repeat (2) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
